// File: rtl/mux.sv
// Registered 8:1 lane multiplexer with capture enable, select echo and one-hot select decode.
// Every output comes straight from a flop, so there is no combinational input-to-output path.
module mux #(
    parameter int WIDTH = 1,
    parameter int N_IN  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   d,
    input  logic [2:0]              s,
    input  logic                    en,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [2:0]              sel_q,
    output logic [7:0]              sel_onehot
);

    logic [WIDTH-1:0] w_lane;
    logic [7:0]       w_onehot;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [2:0]       r_sel_q;
    logic [7:0]       r_sel_onehot;

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (s == 3'(i)) begin
                w_lane = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_onehot = 8'b1 << s;

    // Reset value of the one-hot decode matches sel_q=0 so the pair stays consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_sel_q      <= 3'd0;
            r_sel_onehot <= 8'h01;
        end else begin
            r_out_valid <= en;
            if (en) begin
                r_out        <= w_lane;
                r_sel_q      <= s;
                r_sel_onehot <= w_onehot;
            end
        end
    end

    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign sel_q      = r_sel_q;
    assign sel_onehot = r_sel_onehot;

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: one 1-bit-lane instance and one 4-bit-lane instance share clock, reset,
// select and enable; expected values are hand-computed constants.
module tb_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d1 = 8'h00;
    logic [31:0] d4 = 32'h0;
    logic [2:0]  s = 3'd0;
    logic        en = 1'b0;

    logic [0:0]  o1;
    logic        v1;
    logic [2:0]  q1;
    logic [7:0]  h1;
    logic [3:0]  o4;
    logic        v4;
    logic [2:0]  q4;
    logic [7:0]  h4;

    int n_vec = 0;
    int n_err = 0;

    // d1 = 8'hA6 = 1010_0110, lanes 0..7
    logic       exp_sweep [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_oh    [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    mux #(.WIDTH(1), .N_IN(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .d(d1), .s(s), .en(en),
        .out(o1), .out_valid(v1), .sel_q(q1), .sel_onehot(h1)
    );

    mux #(.WIDTH(4), .N_IN(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .d(d4), .s(s), .en(en),
        .out(o4), .out_valid(v4), .sel_q(q4), .sel_onehot(h4)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; d1 = 8'hA6; d4 = 32'hFFFF_FFFF; s = 3'd5; en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b0)  begin n_err++; $display("FAIL reset_out got=%h exp=0", o1); end
        n_vec++; if (v1 !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b exp=0", v1); end
        n_vec++; if (q1 !== 3'd0)  begin n_err++; $display("FAIL reset_sel_q got=%0d exp=0", q1); end
        n_vec++; if (h1 !== 8'h01) begin n_err++; $display("FAIL reset_onehot got=%h exp=01", h1); end
        n_vec++; if (o4 !== 4'h0)  begin n_err++; $display("FAIL reset_out4 got=%h exp=0", o4); end
        n_vec++; if (h4 !== 8'h01) begin n_err++; $display("FAIL reset_onehot4 got=%h exp=01", h4); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lane_sweep();
        d1 = 8'hA6; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s = 3'(i);
            @(posedge clk);
            #1;
            n_vec++; if (o1 !== exp_sweep[i]) begin n_err++; $display("FAIL sweep_out s=%0d got=%b exp=%b", i, o1, exp_sweep[i]); end
            n_vec++; if (h1 !== exp_oh[i])    begin n_err++; $display("FAIL sweep_onehot s=%0d got=%h exp=%h", i, h1, exp_oh[i]); end
            n_vec++; if (q1 !== 3'(i))        begin n_err++; $display("FAIL sweep_sel_q s=%0d got=%0d", i, q1); end
            n_vec++; if (v1 !== 1'b1)         begin n_err++; $display("FAIL sweep_valid s=%0d got=%b exp=1", i, v1); end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        d1 = 8'hA6; s = 3'd5; en = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b1) begin n_err++; $display("FAIL hold_capture got=%b exp=1", o1); end
        @(negedge clk);
        en = 1'b0; d1 = 8'h00; s = 3'd2;
        #1;
        n_vec++; if (o1 !== 1'b1 || q1 !== 3'd5) begin n_err++; $display("FAIL hold_between_edges out=%b sel_q=%0d exp out=1 sel_q=5", o1, q1); end
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b1)  begin n_err++; $display("FAIL hold_out got=%b exp=1", o1); end
        n_vec++; if (q1 !== 3'd5)  begin n_err++; $display("FAIL hold_sel_q got=%0d exp=5", q1); end
        n_vec++; if (v1 !== 1'b0)  begin n_err++; $display("FAIL hold_valid got=%b exp=0", v1); end
        n_vec++; if (h1 !== 8'h20) begin n_err++; $display("FAIL hold_onehot got=%h exp=20", h1); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        d1 = 8'hA6; s = 3'd2; en = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b1) begin n_err++; $display("FAIL async_pre got=%b exp=1", o1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (o1 !== 1'b0)  begin n_err++; $display("FAIL async_out got=%b exp=0", o1); end
        n_vec++; if (v1 !== 1'b0)  begin n_err++; $display("FAIL async_valid got=%b exp=0", v1); end
        n_vec++; if (q1 !== 3'd0)  begin n_err++; $display("FAIL async_sel_q got=%0d exp=0", q1); end
        n_vec++; if (h1 !== 8'h01) begin n_err++; $display("FAIL async_onehot got=%h exp=01", h1); end
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b0 || v1 !== 1'b0) begin n_err++; $display("FAIL async_held out=%b valid=%b exp 0 0", o1, v1); end
        @(negedge clk);
        rst_n = 1'b1; s = 3'd7;
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b1 || v1 !== 1'b1) begin n_err++; $display("FAIL first_capture out=%b valid=%b exp 1 1", o1, v1); end
        n_vec++; if (h1 !== 8'h80) begin n_err++; $display("FAIL first_capture_onehot got=%h exp=80", h1); end
    endtask

    task automatic test_wide();
        logic [2:0] sels [3] = '{3'd6, 3'd0, 3'd7};
        logic [3:0] exps [3] = '{4'h6, 4'h0, 4'h7};
        d4 = 32'h7654_3210; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = sels[i];
            @(posedge clk);
            #1;
            n_vec++; if (o4 !== exps[i]) begin n_err++; $display("FAIL wide_out s=%0d got=%h exp=%h", sels[i], o4, exps[i]); end
            n_vec++; if (v4 !== 1'b1)    begin n_err++; $display("FAIL wide_valid s=%0d got=%b exp=1", sels[i], v4); end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        d1 = 8'h00; s = 3'd0; en = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b0) begin n_err++; $display("FAIL simul_pre got=%b exp=0", o1); end
        #3;
        d1 = 8'h02; s = 3'd1;
        @(posedge clk);
        #1;
        n_vec++; if (o1 !== 1'b1 || q1 !== 3'd1) begin n_err++; $display("FAIL simul_capture out=%b sel_q=%0d exp out=1 sel_q=1", o1, q1); end
        n_vec++; if (h1 !== 8'h02) begin n_err++; $display("FAIL simul_onehot got=%h exp=02", h1); end
    endtask

    initial begin
        test_reset();
        test_lane_sweep();
        test_hold();
        test_async_reset();
        test_wide();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of each data lane and of out.
REQ-002 Parameter N_IN, default 8, SHALL set the number of data lanes, fixed at 8 because the select field is 3 bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port d, input, N_IN*WIDTH, SHALL carry the data lanes; lane i occupies d[i*WIDTH +: WIDTH].
REQ-006 Port s, input, 3, SHALL be the lane select; s=0 selects lane 0 and s=7 selects lane 7.
REQ-007 Port en, input, 1, SHALL be the capture enable.
REQ-008 Port out, output, WIDTH, SHALL be the registered selected lane.
REQ-009 Port out_valid, output, 1, SHALL be high in the cycle after a capture.
REQ-010 Port sel_q, output, 3, SHALL be the registered copy of the select value used for the current out.
REQ-011 Port sel_onehot, output, 8, SHALL be the registered one-hot decode of sel_q.

Function
REQ-012 On a rising clk edge with en=1, out SHALL load lane s of d, sampled at that edge; latency is 1 cycle.
REQ-013 On the same edge, sel_q SHALL load s and sel_onehot SHALL load (1 << s).
REQ-014 On a rising clk edge with en=0, out, sel_q and sel_onehot SHALL hold their values.
REQ-015 out_valid SHALL equal en registered: 1 after an edge with en=1, 0 after an edge with en=0.
REQ-016 Changes on d or s between edges SHALL NOT affect any output until the next enabled edge.
REQ-017 Every select value 0..7 SHALL be legal, and no error condition exists.
REQ-018 sel_onehot SHALL always have exactly one bit set, except in reset, when it SHALL be 8'h01.
REQ-019 Consecutive enabled cycles SHALL each produce a new out with no bubble; there is no throughput limit.
REQ-020 If d and s change together at an edge, the values present at that edge SHALL be used.
REQ-021 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-022 While rst_n=0, independent of clk, outputs SHALL be forced to: out=0, out_valid=0, sel_q=0, sel_onehot=8'h01.
REQ-023 Reset assertion mid-operation SHALL override any capture in progress.
REQ-024 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high.
REQ-025 The first capture after reset release SHALL follow REQ-012 with no additional delay.

Verification
REQ-026 Reset check: hold rst_n=0 with any d and s -> out=0, out_valid=0, sel_q=0, sel_onehot=8'h01.
REQ-027 Lane sweep: WIDTH=1, d=8'hA6, en=1, s stepped 0..7 on consecutive cycles -> out one cycle later SHALL be 0,1,1,0,0,1,0,1, and sel_onehot SHALL be 01,02,04,...,80.
REQ-028 Hold check: capture s=5 with d=8'hA6 (out=1), then set en=0 and change d=8'h00 and s=2 -> out=1 and sel_q=5 SHALL be held, and out_valid SHALL be 0.
REQ-029 Async reset mid-stream: assert rst_n low between clock edges during a sweep -> outputs SHALL reset immediately, without waiting for clk.
REQ-030 Wide lanes: WIDTH=4, d=32'h7654_3210, s=6, en=1 -> out=4'h6 one cycle later, with out_valid=1.
REQ-031 Simultaneous change: d and s updated at the capture edge -> out SHALL reflect the values present at that edge.
